uncached_store_buffer: RTL and testbench
========================================

// Module: uncached_store_buffer
// PURPOSE
//   Posted-write buffer between the mips core data port and the data port of
//   cpu_axi_adapter_system_cache. Uncached stores (MMIO, UART, LEDs) are acked in one cycle and
//   drained to the adapter in order. All other requests pass through only once the buffer is
//   empty, so the memory order of the program is preserved.
// PARAMETERS
//   DEPTH       4   FIFO entries; must be a power of two and >= 2
//   PTR_W       2   log2(DEPTH); the team sets it to match DEPTH
// PORTS
//   clk            in   1   single clock
//   resetn         in   1   asynchronous, active-low reset
//   cpu_req        in   1   core request valid (SRAM-like)
//   cpu_wr         in   1   1 = store
//   cpu_size       in   2   0 = byte, 1 = half, 2 = word
//   cpu_addr       in   32  physical address
//   cpu_wdata      in   32  store data
//   cpu_uncached   in   1   uncached attribute
//   cpu_rdata      out  32  load data returned to the core
//   cpu_addr_ok    out  1   request accepted this cycle
//   cpu_data_ok    out  1   request completed (load data valid / store done)
//   mem_req/mem_wr/mem_size/mem_addr/mem_wdata/mem_uncached  out  1/1/2/32/32/1  to adapter
//   mem_rdata      in   32  adapter load data
//   mem_addr_ok    in   1   adapter accepted the request
//   mem_data_ok    in   1   adapter completed the request
//   buf_empty      out  1   FIFO empty and no drain in flight (used by SYNC and the cache ops)
// BEHAVIOUR
//   Reset (async, resetn=0): FIFO emptied, pointers/count=0, state=S_IDLE, ack_q=0.
//     At reset: mem_req=0, cpu_addr_ok=0, cpu_data_ok=0, buf_empty=1. Any in-flight work is dropped.
//   Posted store: cpu_req & cpu_wr & cpu_uncached & count<DEPTH & state!=S_PASS_WAIT
//     -> cpu_addr_ok=1 (combinational); {addr,wdata,size} written at wr_ptr; ack_q set.
//     -> cpu_data_ok=1 on the next cycle (from ack_q). A full FIFO blocks the store, even if
//        a pop happens in the same cycle.
//   FSM (one outstanding downstream transaction):
//     S_IDLE: if count!=0, present the head: mem_req=1, mem_wr=1, mem_uncached=1, head fields.
//             On mem_addr_ok go to S_DRAIN_WAIT.
//             Else if cpu_req and the request is not a posted store, forward the cpu_* fields
//             combinationally to mem_*. cpu_addr_ok=mem_addr_ok. On the handshake go to S_PASS_WAIT.
//     S_DRAIN_WAIT: mem_req=0. On mem_data_ok, pop (rd_ptr++ with wrap, count--) and go to S_IDLE.
//     S_PASS_WAIT: mem_req=0, cpu_addr_ok=0. cpu_data_ok=mem_data_ok, cpu_rdata=mem_rdata.
//             On mem_data_ok go to S_IDLE.
//   Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
//   A cached or uncached load to an address held in the FIFO is ordered by the drain-first
//     rule; no forwarding.
//   cpu_data_ok never fires twice in a cycle: ack_q can only be set outside S_PASS_WAIT, and
//     a pass-through needs an empty FIFO.
//   cpu_rdata=mem_rdata at all times (valid only with a pass-through data_ok).
//   buf_empty = (count==0) & (state!=S_DRAIN_WAIT).
//   mem_size/mem_addr/mem_wdata are don't-care when mem_req=0; they are driven from the head.
// STRUCTURE
//   Shared package cpu_bus_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, the sb_entry_t struct
//     {addr,wdata,size}, and the state enum {S_IDLE,S_DRAIN_WAIT,S_PASS_WAIT}.
//   One sub-module: sb_fifo (DEPTH x sb_entry_t, push/pop/count/full/empty, async clear).
//   FSM, ack_q and the mux stay in uncached_store_buffer.
// TESTING
//   1 Single posted store: SW 0x1234_5678 to 0xBFAF_F000 -> addr_ok in the same cycle, data_ok
//     at +1; mem_req with the same fields once the core side is idle; buf_empty=1 after mem_data_ok.
//   2 Fill: 5 back-to-back uncached stores, adapter stalled (mem_addr_ok=0) -> 4 accepted,
//     5th addr_ok=0 until the first pop; drain order matches issue order.
//   3 Ordering: 2 posted stores then a cached LW 0x8000_0100 -> the LW reaches mem_req only
//     after both mem_data_ok; cpu_rdata=mem_rdata with cpu_data_ok.
//   4 Simultaneous: push while the head pops with count=DEPTH-1 -> count stays 3; wrap of
//     rd_ptr/wr_ptr past 3->0 is checked with a scoreboard.
//   5 Reset mid-drain: resetn=0 in S_DRAIN_WAIT -> mem_req=0, buf_empty=1 at once;
//     after release a new store behaves as in test 1.
//   6 Pass-through store: cached SB to 0x8000_0003 -> forwarded, no FIFO entry;
//     cpu_data_ok mirrors mem_data_ok.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
//   Shared definitions for the core-side data bus and the uncached store buffer:
//   access size encodings, the FIFO entry layout and the store-buffer state enum.
package cpu_bus_pkg;

    // Access size encodings on cpu_size / mem_size
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // One posted store waiting to be drained
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } sb_entry_t;

    // Downstream transaction tracking: at most one request outstanding at the adapter
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_DRAIN_WAIT = 2'd1,
        S_PASS_WAIT  = 2'd2
    } sb_state_t;

endpackage

// File: rtl/sb_fifo.sv
// sb_fifo
//   In-order FIFO of posted stores (DEPTH entries of sb_entry_t).
//   Ports:
//     clk, resetn  - clock, asynchronous active-low clear of pointers and count
//     push, din    - write din at the tail (ignored when full)
//     pop          - drop the head entry (ignored when empty)
//     dout         - head entry
//     count        - number of valid entries, 0..DEPTH
//     full, empty  - occupancy flags
module sb_fifo
    import cpu_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            push,
    input  logic            pop,
    input  sb_entry_t       din,
    output sb_entry_t       dout,
    output logic [PTR_W:0]  count,
    output logic            full,
    output logic            empty
);

    sb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
    // push and pop moves both pointers and leaves count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uncached_store_buffer.sv
// uncached_store_buffer
//   Posted-write buffer between the core data port and the cache/AXI adapter.
//   Uncached stores are acknowledged immediately and drained in order; every other
//   request is forwarded only when the buffer is empty, so program order is kept.
//   Ports:
//     clk, resetn            - clock, asynchronous active-low reset
//     cpu_req/wr/size/addr/wdata/uncached  - core request (SRAM-like)
//     cpu_rdata, cpu_addr_ok, cpu_data_ok  - core responses
//     mem_req/wr/size/addr/wdata/uncached  - request to the adapter
//     mem_rdata, mem_addr_ok, mem_data_ok  - adapter responses
//     buf_empty              - no buffered store and no drain in flight
module uncached_store_buffer
    import cpu_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_uncached,
    output logic [31:0] cpu_rdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_uncached,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    output logic        buf_empty
);

    sb_state_t      state;
    logic           ack_q;
    logic           unc_store;
    logic           push;
    logic           pop;
    logic           pass_req;
    logic           pass_fire;
    logic           drain_fire;
    sb_entry_t      new_entry;
    sb_entry_t      head;
    logic [PTR_W:0] count;
    logic           full;
    logic           empty;

    // A posted store needs a free slot before the edge; a pop in the same cycle
    // does not make room. Stores are also held off while a pass-through is pending.
    assign unc_store  = cpu_req & cpu_wr & cpu_uncached;
    assign push       = unc_store & ~full & (state != S_PASS_WAIT);
    assign pass_req   = (state == S_IDLE) & empty & cpu_req & ~unc_store;
    assign pass_fire  = pass_req & mem_addr_ok;
    assign drain_fire = (state == S_IDLE) & ~empty & mem_addr_ok;
    assign pop        = (state == S_DRAIN_WAIT) & mem_data_ok;

    assign new_entry = '{addr: cpu_addr, wdata: cpu_wdata, size: cpu_size};

    sb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (new_entry),
        .dout   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Downstream mux: the buffered head always has priority over a new core
    // request; with nothing outstanding the head fields are left on the bus.
    always_comb begin
        mem_req      = 1'b0;
        mem_wr       = 1'b1;
        mem_uncached = 1'b1;
        mem_size     = head.size;
        mem_addr     = head.addr;
        mem_wdata    = head.wdata;
        if (state == S_IDLE) begin
            if (!empty) begin
                mem_req = 1'b1;
            end else if (pass_req) begin
                mem_req      = 1'b1;
                mem_wr       = cpu_wr;
                mem_uncached = cpu_uncached;
                mem_size     = cpu_size;
                mem_addr     = cpu_addr;
                mem_wdata    = cpu_wdata;
            end
        end
    end

    // ack_q and a pass-through completion can never coincide, since ack_q is
    // only set outside S_PASS_WAIT and a pass-through needs an empty buffer.
    assign cpu_addr_ok = push | pass_fire;
    assign cpu_data_ok = ack_q | ((state == S_PASS_WAIT) & mem_data_ok);
    assign cpu_rdata   = mem_rdata;
    assign buf_empty   = (count == '0) & (state != S_DRAIN_WAIT);

    // One outstanding adapter transaction: either a drain of the head or a
    // forwarded core request, each waiting for its mem_data_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            ack_q <= 1'b0;
        end else begin
            ack_q <= push;
            case (state)
                S_IDLE: begin
                    if (drain_fire) begin
                        state <= S_DRAIN_WAIT;
                    end else if (pass_fire) begin
                        state <= S_PASS_WAIT;
                    end
                end
                S_DRAIN_WAIT: begin
                    if (mem_data_ok) begin
                        state <= S_IDLE;
                    end
                end
                S_PASS_WAIT: begin
                    if (mem_data_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uncached_store_buffer.sv
// tb_uncached_store_buffer
//   Drives a core request stream and a randomly stalling adapter, and checks the
//   buffer every cycle against a transaction-level reference: a queue of posted
//   stores, one outstanding adapter transaction, and the drain-first ordering rule.
module tb_uncached_store_buffer;
    import cpu_bus_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_req;
    logic        cpu_wr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_uncached;
    logic [31:0] cpu_rdata;
    logic        cpu_addr_ok;
    logic        cpu_data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_uncached;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic        buf_empty;

    always #5 clk = ~clk;

    uncached_store_buffer #(
        .DEPTH (4),
        .PTR_W (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cpu_req      (cpu_req),
        .cpu_wr       (cpu_wr),
        .cpu_size     (cpu_size),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_uncached (cpu_uncached),
        .cpu_rdata    (cpu_rdata),
        .cpu_addr_ok  (cpu_addr_ok),
        .cpu_data_ok  (cpu_data_ok),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_uncached (mem_uncached),
        .mem_rdata    (mem_rdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .buf_empty    (buf_empty)
    );

    typedef struct {
        logic        wr;
        logic        unc;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t      req_q[$];
    sb_entry_t exp_fifo[$];
    req_t      cur;
    logic      core_busy;
    logic      cur_issued;
    logic      adp_busy;
    logic      adp_drain;
    logic      exp_ack;
    int        addr_ok_pct;
    int        data_ok_pct;
    int        gap_pct;
    int        n_checks;
    int        n_fail;

    // Every comparison in the bench goes through here
    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    function automatic req_t make_req(input logic wr, input logic unc, input logic [1:0] size,
                                      input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.wr    = wr;
        r.unc   = unc;
        r.size  = size;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    // Mix: 50% uncached store, 20% cached store, 15% cached load, 15% uncached load
    function automatic req_t gen_req();
        int kind;
        kind = int'($urandom_range(99));
        return make_req(kind < 70, (kind < 50) || (kind >= 85),
                        2'($urandom_range(2)), $urandom, $urandom);
    endfunction

    // One clock cycle: drive core and adapter at the falling edge, check all
    // outputs against the reference, then advance the reference at the rising edge.
    task automatic apply_stimulus();
        logic unc_st;
        logic e_push;
        logic e_pass;
        logic e_mem_req;
        logic e_addr_ok;
        logic e_data_ok;
        logic drain_sel;
        logic pass_done;
        sb_entry_t hd;
        @(negedge clk);
        if (!core_busy && req_q.size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
            cur        = req_q.pop_front();
            core_busy  = 1'b1;
            cur_issued = 1'b0;
        end
        cpu_req      = core_busy && !cur_issued;
        cpu_wr       = cpu_req ? cur.wr    : 1'($urandom);
        cpu_uncached = cpu_req ? cur.unc   : 1'($urandom);
        cpu_size     = cpu_req ? cur.size  : 2'($urandom);
        cpu_addr     = cpu_req ? cur.addr  : $urandom;
        cpu_wdata    = cpu_req ? cur.wdata : $urandom;
        mem_addr_ok  = !adp_busy && (int'($urandom_range(99)) < addr_ok_pct);
        mem_data_ok  = adp_busy && (int'($urandom_range(99)) < data_ok_pct);
        mem_rdata    = $urandom;
        #1;
        unc_st    = cpu_req && cur.wr && cur.unc;
        e_push    = unc_st && exp_fifo.size() < DEPTH && !(adp_busy && !adp_drain);
        e_pass    = cpu_req && !unc_st && exp_fifo.size() == 0 && !adp_busy;
        drain_sel = exp_fifo.size() != 0;
        e_mem_req = !adp_busy && (drain_sel || e_pass);
        e_addr_ok = e_push || (e_pass && mem_addr_ok);
        pass_done = adp_busy && !adp_drain && mem_data_ok;
        e_data_ok = exp_ack || pass_done;
        check_output("mem_req", mem_req, e_mem_req);
        check_output("cpu_addr_ok", cpu_addr_ok, e_addr_ok);
        check_output("cpu_data_ok", cpu_data_ok, e_data_ok);
        check_output("buf_empty", buf_empty, exp_fifo.size() == 0);
        if (e_mem_req && drain_sel) begin
            hd = exp_fifo[0];
            check_output("drain_addr", mem_addr, hd.addr);
            check_output("drain_wdata", mem_wdata, hd.wdata);
            check_output("drain_size", mem_size, hd.size);
            check_output("drain_wr_unc", {mem_wr, mem_uncached}, 2'b11);
        end else if (e_mem_req) begin
            check_output("pass_addr", mem_addr, cur.addr);
            check_output("pass_wdata", mem_wdata, cur.wdata);
            check_output("pass_size", mem_size, cur.size);
            check_output("pass_wr_unc", {mem_wr, mem_uncached}, {cur.wr, cur.unc});
        end
        if (pass_done) begin
            check_output("cpu_rdata", cpu_rdata, mem_rdata);
        end
        @(posedge clk);
        exp_ack = e_push;
        if (adp_busy && mem_data_ok) begin
            if (adp_drain) begin
                void'(exp_fifo.pop_front());
            end else begin
                core_busy = 1'b0;
            end
            adp_busy = 1'b0;
        end
        if (e_addr_ok) begin
            cur_issued = 1'b1;
            if (e_push) begin
                exp_fifo.push_back('{addr: cur.addr, wdata: cur.wdata, size: cur.size});
                core_busy = 1'b0;
            end
        end
        if (e_mem_req && mem_addr_ok) begin
            adp_busy  = 1'b1;
            adp_drain = drain_sel;
        end
        #1;
    endtask

    // Reset asserted asynchronously mid-cycle; outputs must clear immediately
    task automatic do_reset();
        @(negedge clk);
        cpu_req     = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        resetn      = 1'b0;
        #1;
        check_output("rst_mem_req", mem_req, 1'b0);
        check_output("rst_addr_ok", cpu_addr_ok, 1'b0);
        check_output("rst_data_ok", cpu_data_ok, 1'b0);
        check_output("rst_buf_empty", buf_empty, 1'b1);
        exp_fifo.delete();
        req_q.delete();
        core_busy  = 1'b0;
        cur_issued = 1'b0;
        adp_busy   = 1'b0;
        adp_drain  = 1'b0;
        exp_ack    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic run_until_idle(input int limit);
        int cyc;
        cyc = 0;
        while (!(req_q.size() == 0 && !core_busy && exp_fifo.size() == 0 && !adp_busy)
               && cyc < limit) begin
            apply_stimulus();
            cyc++;
        end
        check_output("idle_timeout", cyc < limit, 1'b1);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        resetn       = 1'b0;
        cpu_req      = 1'b0;
        cpu_wr       = 1'b0;
        cpu_size     = SZ_WORD;
        cpu_addr     = '0;
        cpu_wdata    = '0;
        cpu_uncached = 1'b0;
        mem_rdata    = '0;
        mem_addr_ok  = 1'b0;
        mem_data_ok  = 1'b0;
        addr_ok_pct  = 100;
        data_ok_pct  = 100;
        gap_pct      = 0;
        do_reset();

        $display("[TB] single posted store");
        req_q.push_back(make_req(1'b1, 1'b1, SZ_WORD, 32'hBFAF_F000, 32'h1234_5678));
        run_until_idle(50);
        check_output("t1_buf_empty", buf_empty, 1'b1);

        $display("[TB] fill with stalled adapter");
        addr_ok_pct = 0;
        for (int i = 0; i < 5; i++) begin
            req_q.push_back(make_req(1'b1, 1'b1, SZ_WORD, 32'hBFD0_0000 + 32'(4 * i),
                                     32'hA000_0000 + 32'(i)));
        end
        repeat (10) apply_stimulus();
        check_output("t2_buf_not_empty", buf_empty, 1'b0);
        addr_ok_pct = 100;
        run_until_idle(100);

        $display("[TB] stores then cached load");
        data_ok_pct = 50;
        req_q.push_back(make_req(1'b1, 1'b1, SZ_WORD, 32'hBFAF_F004, 32'h1111_1111));
        req_q.push_back(make_req(1'b1, 1'b1, SZ_HALF, 32'hBFAF_F008, 32'h2222_2222));
        req_q.push_back(make_req(1'b0, 1'b0, SZ_WORD, 32'h8000_0100, 32'h0));
        run_until_idle(100);

        $display("[TB] push during pop with pointer wrap");
        data_ok_pct = 100;
        for (int i = 0; i < 12; i++) begin
            req_q.push_back(make_req(1'b1, 1'b1, 2'($urandom_range(2)), $urandom, $urandom));
        end
        run_until_idle(200);

        $display("[TB] reset during drain");
        data_ok_pct = 0;
        req_q.push_back(make_req(1'b1, 1'b1, SZ_WORD, 32'hBFAF_F010, 32'hDEAD_BEEF));
        for (int i = 0; i < 10 && !adp_busy; i++) begin
            apply_stimulus();
        end
        check_output("t5_pre_buf_empty", buf_empty, 1'b0);
        do_reset();
        data_ok_pct = 100;
        req_q.push_back(make_req(1'b1, 1'b1, SZ_WORD, 32'hBFAF_F000, 32'h1234_5678));
        run_until_idle(50);

        $display("[TB] cached byte store passes through");
        data_ok_pct = 40;
        req_q.push_back(make_req(1'b1, 1'b0, SZ_BYTE, 32'h8000_0003, 32'h0000_00AB));
        run_until_idle(100);
        check_output("t6_buf_empty", buf_empty, 1'b1);

        $display("[TB] random traffic");
        for (int seg = 0; seg < 8; seg++) begin
            addr_ok_pct = int'($urandom_range(100, 20));
            data_ok_pct = int'($urandom_range(100, 20));
            gap_pct     = int'($urandom_range(50));
            for (int i = 0; i < 50; i++) begin
                req_q.push_back(gen_req());
            end
            run_until_idle(3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
